// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit serialiser: SYNC, LSB-first data with bit stuffing,
// NRZI onto D+/D-, and EOP. Bytes arrive over a valid/ready handshake.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STUFF_LEN + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STUFF_LEN);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [SW-1:0] stuff_cnt, stuff_cnt_n;
  logic          cur_stuff, cur_stuff_n;
  logic          last_q, last_n;
  logic          err_q, err_n;
  logic          start_pend, start_pend_n;
  logic          dp_n, dm_n, busy_n, done_n, error_n;
  logic          send_en, send_val;
  logic          period_end, stuff_due, byte_end;

  assign period_end = (timer == T_LAST);
  assign stuff_due  = !cur_stuff && (stuff_cnt == S_MAX);
  // Last clock of a byte's final period, counting any owed stuff bit.
  assign byte_end   = period_end && (bit_idx == 3'd7) && !stuff_due;
  assign tx_ready   = byte_end && ((state == SYNC) || (state == DATA && !last_q));

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    stuff_cnt_n  = stuff_cnt;
    cur_stuff_n  = cur_stuff;
    last_n       = last_q;
    err_n        = err_q;
    start_pend_n = start_pend;
    dp_n         = d_plus;
    dm_n         = d_minus;
    busy_n       = tx_busy;
    done_n       = 1'b0;
    error_n      = 1'b0;
    send_en      = 1'b0;
    send_val     = 1'b0;

    unique case (state)
      IDLE: begin
        timer_n      = '0;
        start_pend_n = tx_start;
        if (start_pend) begin
          // SYNC (0x80) goes through the same shifter as data bytes.
          state_n      = SYNC;
          start_pend_n = 1'b0;
          busy_n       = 1'b1;
          err_n        = 1'b0;
          last_n       = 1'b0;
          bit_idx_n    = '0;
          stuff_cnt_n  = '0;
          shreg_n      = 8'h40;
          send_en      = 1'b1;
          send_val     = 1'b0;
        end
      end
      SYNC, DATA: begin
        timer_n = period_end ? '0 : timer + 1'b1;
        if (period_end) begin
          if (stuff_due) begin
            dp_n        = ~d_plus;
            dm_n        = ~d_minus;
            stuff_cnt_n = '0;
            cur_stuff_n = 1'b1;
          end else if (bit_idx != 3'd7) begin
            bit_idx_n = bit_idx + 3'd1;
            send_en   = 1'b1;
            send_val  = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end else if (state == DATA && last_q) begin
            state_n     = EOP_SE0;
            bit_idx_n   = '0;
            cur_stuff_n = 1'b0;
            dp_n        = 1'b0;
            dm_n        = 1'b0;
          end else if (tx_valid) begin
            state_n   = DATA;
            last_n    = tx_last;
            bit_idx_n = '0;
            send_en   = 1'b1;
            send_val  = tx_data[0];
            shreg_n   = {1'b0, tx_data[7:1]};
          end else begin
            state_n     = EOP_SE0;
            error_n     = 1'b1;
            err_n       = 1'b1;
            bit_idx_n   = '0;
            cur_stuff_n = 1'b0;
            dp_n        = 1'b0;
            dm_n        = 1'b0;
          end
        end
      end
      EOP_SE0: begin
        timer_n = period_end ? '0 : timer + 1'b1;
        if (period_end) begin
          if (bit_idx == 3'd1) begin
            state_n = EOP_J;
            dp_n    = 1'b1;
            dm_n    = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      EOP_J: begin
        timer_n = period_end ? '0 : timer + 1'b1;
        if (period_end) begin
          state_n = IDLE;
          timer_n = '0;
          busy_n  = 1'b0;
          done_n  = !err_q;
        end
      end
      default: state_n = IDLE;
    endcase

    // NRZI: 0 toggles the line, 1 holds it and advances the run of ones.
    if (send_en) begin
      cur_stuff_n = 1'b0;
      if (send_val) begin
        stuff_cnt_n = stuff_cnt + 1'b1;
      end else begin
        dp_n        = ~d_plus;
        dm_n        = ~d_minus;
        stuff_cnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      stuff_cnt  <= '0;
      cur_stuff  <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      start_pend <= 1'b0;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      stuff_cnt  <= stuff_cnt_n;
      cur_stuff  <= cur_stuff_n;
      last_q     <= last_n;
      err_q      <= err_n;
      start_pend <= start_pend_n;
      d_plus     <= dp_n;
      d_minus    <= dm_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
      tx_error   <= error_n;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line codes per bit period, handshake
// timing, underrun and reset-abort, against hand-computed sequences.
module tb_usb_tx_encoder;
  localparam int CPB = 8;
  localparam logic [1:0] J = 2'b10, K = 2'b01, S = 2'b00;

  logic       tb_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_error, d_plus, d_minus;

  always #5 tb_clk = ~tb_clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LEN(6)) dut (
    .clk(tb_clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .d_plus(d_plus), .d_minus(d_minus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] bq [4];
  int         nbytes, nvalid;
  logic [1:0] ln [512];
  int         len, rdy_n, err_n, err_pos, done_n, viol;
  int         rdy_pos [4];

  function automatic logic [63:0] line_vec(input int nbits);
    logic [63:0] v = '0;
    for (int k = 0; k < nbits; k++) v = {v[61:0], ln[k*CPB + 4]};
    return v;
  endfunction

  task automatic run_pkt();
    int idx = 0;
    int w = 0;
    bit take = 1'b0;
    rdy_n = 0; err_n = 0; err_pos = -1; done_n = 0; viol = 0; len = 0;
    tx_data = bq[0]; tx_valid = (nvalid > 0); tx_last = (nbytes == 1);
    @(negedge tb_clk); tx_start = 1'b1;
    @(negedge tb_clk); tx_start = 1'b0;
    while (!tx_busy && w < 8) begin @(negedge tb_clk); w++; end
    chk("busy_rise", 64'(tx_busy), 64'd1);
    while (tx_busy && len < 500) begin
      if (take) idx++;
      take     = 1'b0;
      tx_valid = (idx < nvalid);
      tx_data  = (idx < 4) ? bq[idx] : 8'h00;
      tx_last  = (idx == nbytes - 1);
      ln[len]  = {d_plus, d_minus};
      if (len % CPB != 0 && ln[len] != ln[len-1]) viol++;
      if (tx_ready) begin
        if (rdy_n < 4) rdy_pos[rdy_n] = len;
        rdy_n++;
        if (tx_valid) take = 1'b1;
      end
      if (tx_error) begin err_n++; err_pos = len; end
      if (tx_done) done_n++;
      @(negedge tb_clk); len++;
    end
    if (tx_done) done_n++;
    @(negedge tb_clk);
    if (tx_done) done_n++;
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] dec;
    // reset state
    repeat (2) @(negedge tb_clk);
    chk("rst_outputs", 64'({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error}), 64'(6'b100000));
    n_rst = 1'b1;
    repeat (3) @(negedge tb_clk);
    chk("idle_outputs", 64'({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error}), 64'(6'b100000));

    // single byte 0x00
    bq[0] = 8'h00; nbytes = 1; nvalid = 1;
    run_pkt();
    chk("b00_len", 64'(len), 64'd152);
    chk("b00_line", line_vec(19), 64'({K,J,K,J,K,J,K,K, J,K,J,K,J,K,J,K, S,S,J}));
    chk("b00_rdy_n", 64'(rdy_n), 64'd1);
    chk("b00_rdy_pos", 64'(rdy_pos[0]), 64'd63);
    chk("b00_done", 64'(done_n), 64'd1);
    chk("b00_err", 64'(err_n), 64'd0);
    chk("b00_edges", 64'(viol), 64'd0);

    // single byte 0xFF: stuff bit after SYNC's 1 plus five data 1s
    bq[0] = 8'hFF; nbytes = 1; nvalid = 1;
    run_pkt();
    chk("bff_len", 64'(len), 64'd160);
    chk("bff_line", line_vec(20), 64'({K,J,K,J,K,J,K,K, K,K,K,K,K,J,J,J,J, S,S,J}));
    chk("bff_rdy_n", 64'(rdy_n), 64'd1);
    chk("bff_done", 64'(done_n), 64'd1);

    // two bytes 0xA5, 0x3C
    bq[0] = 8'hA5; bq[1] = 8'h3C; nbytes = 2; nvalid = 2;
    run_pkt();
    chk("two_len", 64'(len), 64'd216);
    chk("two_line", line_vec(27), 64'({K,J,K,J,K,J,K,K, K,J,J,K,J,J,K,K, J,K,K,K,K,K,J,K, S,S,J}));
    chk("two_rdy_n", 64'(rdy_n), 64'd2);
    chk("two_rdy0", 64'(rdy_pos[0]), 64'd63);
    chk("two_rdy1", 64'(rdy_pos[1]), 64'd127);
    dec = '0;
    for (int k = 8; k < 24; k++) dec = {dec[14:0], ln[k*CPB+4] == ln[(k-1)*CPB+4]};
    chk("two_decoded", 64'(dec), 64'h0000_0000_0000_A53C);
    chk("two_done", 64'(done_n), 64'd1);

    // underrun after 0x12
    bq[0] = 8'h12; nbytes = 2; nvalid = 1;
    run_pkt();
    chk("urun_len", 64'(len), 64'd152);
    chk("urun_line", line_vec(19), 64'({K,J,K,J,K,J,K,K, J,J,K,J,J,K,J,K, S,S,J}));
    chk("urun_err_n", 64'(err_n), 64'd1);
    chk("urun_err_pos", 64'(err_pos), 64'd128);
    chk("urun_done", 64'(done_n), 64'd0);
    chk("urun_rdy_n", 64'(rdy_n), 64'd2);

    // reset during data bit 4, then a clean 0x00 packet
    tx_data = 8'h00; tx_valid = 1'b1; tx_last = 1'b1;
    @(negedge tb_clk); tx_start = 1'b1;
    @(negedge tb_clk); tx_start = 1'b0;
    for (int w = 0; w < 8 && !tx_busy; w++) @(negedge tb_clk);
    repeat (99) @(negedge tb_clk);
    n_rst = 1'b0;
    #1;
    chk("abort_outputs", 64'({d_plus, d_minus, tx_busy, tx_ready}), 64'(4'b1000));
    @(negedge tb_clk); n_rst = 1'b1; tx_valid = 1'b0;
    repeat (2) @(negedge tb_clk);
    bq[0] = 8'h00; nbytes = 1; nvalid = 1;
    run_pkt();
    chk("rerun_len", 64'(len), 64'd152);
    chk("rerun_line", line_vec(19), 64'({K,J,K,J,K,J,K,K, J,K,J,K,J,K,J,K, S,S,J}));
    chk("rerun_done", 64'(done_n), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
Full-speed USB serial transmit engine, the transmit-side counterpart of the receive timer/edge-detect path. Accepts packet bytes over a valid/ready handshake and serialises them onto d_plus/d_minus. Prepends SYNC, sends data LSB-first with bit stuffing and NRZI encoding, and terminates each packet with EOP. Sits between the packet/FIFO logic and the bus pads.

Parameters:
CLKS_PER_BIT, 8, clock cycles per USB bit period (minimum 4)
STUFF_LEN, 6, consecutive 1s after which a stuffed 0 is inserted

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
tx_start  input  1  request to begin a packet; sampled only in IDLE
tx_data  input  8  byte to transmit
tx_valid  input  1  tx_data/tx_last valid
tx_last  input  1  current byte is the final byte of the packet
tx_ready  output  1  byte-accept strobe; a byte transfers when tx_valid && tx_ready
tx_busy  output  1  high from packet start through end of EOP
tx_done  output  1  one-cycle pulse when the packet completes normally
tx_error  output  1  one-cycle pulse on underrun
d_plus  output  1  bus D+
d_minus  output  1  bus D-

Behaviour:
- Reset (async): state IDLE; d_plus=1, d_minus=0 (J); tx_ready, tx_busy, tx_done, tx_error=0; stuff counter and bit timer cleared. Reset mid-packet aborts immediately to J with no EOP.
- Bit timer counts 0..CLKS_PER_BIT-1. The line changes only on the clock edge that starts a bit period (timer=0).
- States: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
- IDLE: line J. When tx_start=1 at edge n, at edge n+1 enter SYNC, tx_busy=1, and drive the first SYNC bit. tx_start is ignored while busy.
- SYNC: send 0x80 LSB-first (bits 0000000 then 1). The line sequence is K J K J K J K K. The final 1 counts toward stuffing (stuff count = 1).
- NRZI: a data 0 toggles J<->K; a data 1 holds the line. J = (1,0), K = (0,1).
- Bit stuffing: after STUFF_LEN consecutive transmitted 1s (stuffed bits excluded from the data stream), insert one 0 bit period (toggle) and reset the count. Any 0 also resets the count. A stuff bit owed after bit 7 of the last byte is still sent before EOP.
- Fetch point: the last clock of the final bit period of SYNC or of a non-last byte, including any pending stuff bit. tx_ready=1 for exactly that one cycle and is 0 at all other times.
  - tx_valid=1 at the fetch point: capture tx_data/tx_last; the next bit period starts bit 0.
  - tx_valid=0 at the fetch point: pulse tx_error in the next cycle and go to EOP_SE0.
- After the last byte's final bit or stuff bit: EOP_SE0 drives (0,0) for 2 bit periods, then EOP_J drives J for 1 bit period. Then return to IDLE, tx_busy=0, and pulse tx_done in the same cycle. No tx_done after underrun.
- Packets are unbounded in length; the stuff count carries across byte boundaries.
- The outputs d_plus, d_minus, tx_busy, tx_done and tx_error are registered. tx_ready may be decoded from registered state only, never from inputs.

Test Plan:
- Reset: hold n_rst=0 -> d_plus=1, d_minus=0, tx_ready=tx_busy=tx_done=tx_error=0. Release -> line stays J.
- Single byte 0x00, tx_last=1 (CLKS_PER_BIT=8):
  - Line is KJKJKJKK, then JKJKJKJK, then SE0 for 16 clks, then J for 8 clks.
  - tx_ready pulses once, at clock 63 after start.
  - tx_busy lasts 152 clks; tx_done pulses once at the end.
- Single byte 0xFF, tx_last=1:
  - Line stays K for 6 bit periods (SYNC 1 + 5 data 1s), stuff-toggles to J, then holds J for 3 bits.
  - 17 bit periods precede EOP; total busy is 160 clks.
- Two bytes 0xA5 (last=0) then 0x3C (last=1), tx_valid held high:
  - tx_ready pulses exactly twice, at the end of SYNC and at the end of byte 1.
  - Decoded NRZI bitstream is 10100101 00111100 LSB-first per byte (1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0).
- Underrun: byte 0x12 with last=0, then tx_valid=0 at the second fetch -> tx_error pulses once, then SE0 2 bits, J 1 bit, tx_busy falls, tx_done stays 0.
- Reset mid-DATA: pull n_rst low during bit 4 of a byte -> immediately J, tx_busy=0. After release, a new tx_start with 0x00 reproduces the 152-clk single-byte sequence exactly.
